// File: rtl/vga_compositor_pkg.sv
// Shared timing defaults, per-pixel control word and colour-triplet layout for the compositor.
package vga_compositor_pkg;

   // 640x480@60 defaults
   localparam int unsigned DefHActive = 640;
   localparam int unsigned DefHFp     = 16;
   localparam int unsigned DefHSync   = 96;
   localparam int unsigned DefHBp     = 48;
   localparam int unsigned DefVActive = 480;
   localparam int unsigned DefVFp     = 10;
   localparam int unsigned DefVSync   = 2;
   localparam int unsigned DefVBp     = 33;

   // Channel position inside a packed {R,G,B} triplet; R sits in the top slice.
   typedef enum logic [1:0] {
      ChB = 2'd0,
      ChG = 2'd1,
      ChR = 2'd2
   } chan_e;

   localparam int unsigned NumCh = 3;

   // Control travelling alongside each pixel through the blend pipeline.
   typedef struct packed {
      logic act;   // visible pixel
      logic hs_n;  // horizontal sync, active-low
      logic vs_n;  // vertical sync, active-low
   } pix_ctl_t;

   localparam pix_ctl_t CtlBlank = '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

   function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                           input int unsigned sync, input int unsigned bp);
      return act + fp + sync + bp;
   endfunction

   // LSB of a channel inside a packed triplet of cw-bit channels.
   function automatic int unsigned chan_lsb(input chan_e ch, input int unsigned cw);
      return 32'(ch) * cw;
   endfunction

endpackage

// File: rtl/alpha_blend_stage.sv
// One registered alpha-blend stage: composites a single layer over the accumulated colour.
module alpha_blend_stage
   import vga_compositor_pkg::*;
#(
   parameter int unsigned COLOR_W = 8,
   parameter int unsigned ALPHA_W = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NumCh*COLOR_W-1:0] c_i,
   input  pix_ctl_t                 ctl_i,
   input  logic [NumCh*COLOR_W-1:0] fg_i,
   input  logic [ALPHA_W-1:0]       alpha_i,
   input  logic                     en_i,
   output logic [NumCh*COLOR_W-1:0] c_o,
   output pix_ctl_t                 ctl_o
);

   // a*fg + (AMAX-a)*c + half never exceeds 2^(COLOR_W+ALPHA_W)-1, so this width cannot overflow.
   localparam int unsigned ProdW = COLOR_W + ALPHA_W;
   localparam logic [ALPHA_W-1:0] AMax = '1;
   localparam logic [ProdW-1:0] Half = ProdW'(1) << (ALPHA_W - 1);

   logic [NumCh*COLOR_W-1:0] c_d;
   logic [ProdW-1:0]         acc;

   // Blend: disabled/transparent passes through, opaque replaces exactly, else rounded mix.
   always_comb begin
      c_d = c_i;
      acc = '0;
      if (en_i && (alpha_i == AMax)) begin
         c_d = fg_i;
      end else if (en_i && (alpha_i != '0)) begin
         for (int ch = 0; ch < int'(NumCh); ch++) begin
            acc = ProdW'(alpha_i) * ProdW'(fg_i[ch*COLOR_W +: COLOR_W])
                + ProdW'(AMax - alpha_i) * ProdW'(c_i[ch*COLOR_W +: COLOR_W])
                + Half;
            c_d[ch*COLOR_W +: COLOR_W] = COLOR_W'(acc >> ALPHA_W);
         end
      end
   end

   // Stage register; reset leaves the slot blanked.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         c_o   <= '0;
         ctl_o <= CtlBlank;
      end else begin
         c_o   <= c_d;
         ctl_o <= ctl_i;
      end
   end

endmodule

// File: rtl/vga_layer_compositor.sv
// VGA timing generator with a NUM_LAYERS-deep alpha-compositing pipeline over an SDRAM background.
module vga_layer_compositor
   import vga_compositor_pkg::*;
#(
   parameter int unsigned NUM_LAYERS = 4,
   parameter int unsigned COLOR_W    = 8,
   parameter int unsigned ALPHA_W    = 8,
   parameter int unsigned H_ACTIVE   = DefHActive,
   parameter int unsigned H_FP       = DefHFp,
   parameter int unsigned H_SYNC     = DefHSync,
   parameter int unsigned H_BP       = DefHBp,
   parameter int unsigned V_ACTIVE   = DefVActive,
   parameter int unsigned V_FP       = DefVFp,
   parameter int unsigned V_SYNC     = DefVSync,
   parameter int unsigned V_BP       = DefVBp,
   parameter int unsigned ADDR_W     = 20
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NumCh*COLOR_W-1:0]             bg_rgb,
   input  logic [NUM_LAYERS*NumCh*COLOR_W-1:0]  layer_rgb,
   input  logic [NUM_LAYERS*ALPHA_W-1:0]        layer_alpha,
   input  logic [NUM_LAYERS-1:0]                layer_en,
   output logic [COLOR_W-1:0]                   R,
   output logic [COLOR_W-1:0]                   G,
   output logic [COLOR_W-1:0]                   B,
   output logic                                 HS,
   output logic                                 VS,
   output logic                                 BLANK,
   output logic                                 VGA_SYNC,
   output logic                                 VGA_CLK,
   output logic [9:0]                           h_pos,
   output logic [9:0]                           v_pos,
   output logic [ADDR_W-1:0]                    oAddress,
   output logic                                 frame_start
);

   localparam int unsigned HTotal  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned VTotal  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int unsigned HSyncLo = H_ACTIVE + H_FP;
   localparam int unsigned HSyncHi = H_ACTIVE + H_FP + H_SYNC;
   localparam int unsigned VSyncLo = V_ACTIVE + V_FP;
   localparam int unsigned VSyncHi = V_ACTIVE + V_FP + V_SYNC;
   localparam int unsigned PixW    = NumCh * COLOR_W;
   localparam int unsigned LayW    = 1 + ALPHA_W + PixW;

   logic [9:0]        h_q, h_d, v_q, v_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              fs_q, fs_d;
   // High for the reset-state cycle: the counters read (0,0) but no pixel is issued yet.
   logic              restart_q;

   pix_ctl_t          ctl_cur, ctl0_q, ctl1_q;
   logic [PixW-1:0]   bg_q;
   pix_ctl_t          ctl_s [NUM_LAYERS+1];
   logic [PixW-1:0]   col_s [NUM_LAYERS+1];

   // Counter next-state, plus fetch address and frame pulse derived from the new position.
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (restart_q) begin
         h_d = '0;
         v_d = '0;
      end else if (h_q == 10'(HTotal - 1)) begin
         h_d = '0;
         v_d = (v_q == 10'(VTotal - 1)) ? '0 : v_q + 10'd1;
      end else begin
         h_d = h_q + 10'd1;
      end
      fs_d   = (h_d == '0) && (v_d == '0);
      addr_d = '0;
      if ((h_d < 10'(H_ACTIVE)) && (v_d < 10'(V_ACTIVE))) begin
         addr_d = ADDR_W'(32'(v_d) * H_ACTIVE + 32'(h_d));
      end
   end

   // Position counters and fetch-side outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_q       <= '0;
         v_q       <= '0;
         addr_q    <= '0;
         fs_q      <= 1'b0;
         restart_q <= 1'b1;
      end else begin
         h_q       <= h_d;
         v_q       <= v_d;
         addr_q    <= addr_d;
         fs_q      <= fs_d;
         restart_q <= 1'b0;
      end
   end

   // Visibility and sync flags for the pixel addressed this cycle.
   always_comb begin
      ctl_cur = CtlBlank;
      if (!restart_q) begin
         ctl_cur.act  = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
         ctl_cur.hs_n = !((h_q >= 10'(HSyncLo)) && (h_q < 10'(HSyncHi)));
         ctl_cur.vs_n = !((v_q >= 10'(VSyncLo)) && (v_q < 10'(VSyncHi)));
      end
   end

   // Cover fetch latency: control waits one cycle, then meets the captured background.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctl0_q <= CtlBlank;
         ctl1_q <= CtlBlank;
         bg_q   <= '0;
      end else begin
         ctl0_q <= ctl_cur;
         ctl1_q <= ctl0_q;
         bg_q   <= bg_rgb;
      end
   end

   assign col_s[0] = bg_q;
   assign ctl_s[0] = ctl1_q;

   for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
      // Layer k is captured with the background, then skewed k cycles to reach stage k.
      logic [LayW-1:0] dly_q [k+1];

      // Capture and skew layer k data; blanking is carried by ctl, so no reset here.
      always_ff @(posedge clk) begin
         dly_q[0] <= {layer_en[k], layer_alpha[k*ALPHA_W +: ALPHA_W], layer_rgb[k*PixW +: PixW]};
         for (int i = 1; i <= k; i++) begin
            dly_q[i] <= dly_q[i-1];
         end
      end

      alpha_blend_stage #(
         .COLOR_W(COLOR_W),
         .ALPHA_W(ALPHA_W)
      ) u_stage (
         .clk_i  (clk),
         .rst_i  (rst),
         .c_i    (col_s[k]),
         .ctl_i  (ctl_s[k]),
         .fg_i   (dly_q[k][PixW-1:0]),
         .alpha_i(dly_q[k][PixW +: ALPHA_W]),
         .en_i   (dly_q[k][LayW-1]),
         .c_o    (col_s[k+1]),
         .ctl_o  (ctl_s[k+1])
      );
   end

   localparam int unsigned RLsb = chan_lsb(ChR, COLOR_W);
   localparam int unsigned GLsb = chan_lsb(ChG, COLOR_W);
   localparam int unsigned BLsb = chan_lsb(ChB, COLOR_W);

   assign R           = ctl_s[NUM_LAYERS].act ? col_s[NUM_LAYERS][RLsb +: COLOR_W] : '0;
   assign G           = ctl_s[NUM_LAYERS].act ? col_s[NUM_LAYERS][GLsb +: COLOR_W] : '0;
   assign B           = ctl_s[NUM_LAYERS].act ? col_s[NUM_LAYERS][BLsb +: COLOR_W] : '0;
   assign HS          = ctl_s[NUM_LAYERS].hs_n;
   assign VS          = ctl_s[NUM_LAYERS].vs_n;
   assign BLANK       = ctl_s[NUM_LAYERS].act;
   assign VGA_SYNC    = 1'b0;
   assign VGA_CLK     = ~clk;
   assign h_pos       = h_q;
   assign v_pos       = v_q;
   assign oAddress    = addr_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Scoreboard bench for vga_layer_compositor on a reduced raster, plus a 1-layer 10-bit instance.
module tb_vga_layer_compositor;

   localparam int HA = 16, HF = 2, HSW = 4, HB = 3;
   localparam int VA = 6, VF = 1, VSW = 2, VB = 1;
   localparam int HT = HA + HF + HSW + HB;
   localparam int VT = VA + VF + VSW + VB;
   localparam int NL = 4;
   localparam int LAT = NL + 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [23:0]   bg_rgb;
   logic [95:0]   layer_rgb;
   logic [31:0]   layer_alpha;
   logic [3:0]    layer_en;
   logic [7:0]    R, G, B;
   logic          HS, VS, BLANK, VGA_SYNC, VGA_CLK, frame_start;
   logic [9:0]    h_pos, v_pos;
   logic [19:0]   oAddress;

   logic [29:0]   bg2, l2rgb;
   logic [3:0]    l2a;
   logic          l2en;
   logic [9:0]    R2, G2, B2, h2, v2;
   logic          HS2, VS2, BLANK2, SYNC2, CLK2, fs2;
   logic [19:0]   addr2;

   vga_layer_compositor #(
      .NUM_LAYERS(NL), .COLOR_W(8), .ALPHA_W(8),
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .ADDR_W(20)
   ) u_dut (
      .clk(clk), .rst(rst), .bg_rgb(bg_rgb), .layer_rgb(layer_rgb),
      .layer_alpha(layer_alpha), .layer_en(layer_en), .R(R), .G(G), .B(B),
      .HS(HS), .VS(VS), .BLANK(BLANK), .VGA_SYNC(VGA_SYNC), .VGA_CLK(VGA_CLK),
      .h_pos(h_pos), .v_pos(v_pos), .oAddress(oAddress), .frame_start(frame_start)
   );

   vga_layer_compositor #(
      .NUM_LAYERS(1), .COLOR_W(10), .ALPHA_W(4),
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .ADDR_W(20)
   ) u_dut2 (
      .clk(clk), .rst(rst), .bg_rgb(bg2), .layer_rgb(l2rgb),
      .layer_alpha(l2a), .layer_en(l2en), .R(R2), .G(G2), .B(B2),
      .HS(HS2), .VS(VS2), .BLANK(BLANK2), .VGA_SYNC(SYNC2), .VGA_CLK(CLK2),
      .h_pos(h2), .v_pos(v2), .oAddress(addr2), .frame_start(fs2)
   );

   typedef struct {
      logic [23:0] rgb;
      int          stamp;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_pix   = 0;
   int   cyc     = 0;
   int   mh = 0, mv = 0, maddr = 0, pend_idx = 0;
   bit   mfs = 1'b0, mfirst = 1'b0, mact = 1'b0, rs = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [23:0] rgb(input int r, input int g, input int b);
      return {8'(r), 8'(g), 8'(b)};
   endfunction

   task automatic set_layer(input int k, input logic [23:0] c, input int a, input bit en);
      layer_rgb[k*24 +: 24] = c;
      layer_alpha[k*8 +: 8] = 8'(a);
      layer_en[k]           = en;
   endtask

   // Directed vector table, selected by framebuffer address modulo 8.
   task automatic drive_vec(input int idx);
      bg_rgb = rgb(10, 20, 30);
      for (int k = 0; k < NL; k++) set_layer(k, rgb(99, 99, 99), 255, 1'b0);
      case (idx)
         1: begin set_layer(0, rgb(255, 0, 0), 255, 1'b1); set_layer(3, rgb(0, 0, 255), 128, 1'b1); end
         2: begin bg_rgb = rgb(100, 100, 100); set_layer(1, rgb(200, 0, 50), 0, 1'b1); end
         3: begin bg_rgb = rgb(0, 0, 0); set_layer(2, rgb(255, 255, 255), 128, 1'b1); end
         4: begin bg_rgb = rgb(40, 50, 60); set_layer(3, rgb(1, 2, 3), 255, 1'b0); end
         5: begin
            bg_rgb = rgb(200, 100, 50);
            set_layer(0, rgb(0, 0, 0), 64, 1'b1);
            set_layer(2, rgb(0, 0, 0), 1, 1'b1);
         end
         6: begin set_layer(0, rgb(50, 60, 70), 255, 1'b1); set_layer(3, rgb(7, 8, 9), 255, 1'b1); end
         7: begin
            bg_rgb = rgb(255, 255, 255);
            set_layer(0, rgb(0, 0, 0), 255, 1'b1);
            set_layer(1, rgb(255, 255, 255), 128, 1'b1);
         end
         default: ;
      endcase
   endtask

   function automatic logic [23:0] exp_vec(input int idx);
      case (idx)
         0: return rgb(10, 20, 30);
         1: return rgb(127, 0, 128);
         2: return rgb(100, 100, 100);
         3: return rgb(128, 128, 128);
         4: return rgb(40, 50, 60);
         5: return rgb(148, 74, 37);
         6: return rgb(7, 8, 9);
         default: return rgb(128, 128, 128);
      endcase
   endfunction

   // Raster model, fetch emulation (one-cycle latency) and scoreboard producer.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         rs = rst;
         if (rs) begin
            mh = 0; mv = 0; mfs = 1'b0; mfirst = 1'b1;
            sb_q.delete();
         end else if (mfirst) begin
            mh = 0; mv = 0; mfs = 1'b1; mfirst = 1'b0;
         end else begin
            if (mh == HT - 1) begin
               mh = 0;
               mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
               mh++;
            end
            mfs = (mh == 0) && (mv == 0);
         end
         mact  = !rs && (mh < HA) && (mv < VA);
         maddr = mact ? mv * HA + mh : 0;
         #1;
         drive_vec(pend_idx);
         check("h_pos", 32'(h_pos), 32'(mh));
         check("v_pos", 32'(v_pos), 32'(mv));
         check("oAddress", 32'(oAddress), 32'(maddr));
         check("frame_start", 32'(frame_start), 32'(mfs));
         if (rs) begin
            check("rst_rgb", {8'd0, R, G, B}, 32'd0);
            check("rst_hs_vs_blank", {29'd0, HS, VS, BLANK}, 32'b110);
         end
         if (mact) sb_q.push_back('{rgb: exp_vec(maddr % 8), stamp: cyc});
         pend_idx = maddr % 8;
      end
   end

   // Output monitor: pops one expectation per visible pixel; checks blanking and sync widths.
   initial begin
      int   hs_run = 0;
      int   vs_run = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (BLANK) begin
            check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("pixel_rgb", {8'd0, R, G, B}, {8'd0, e.rgb});
               check("latency", 32'(cyc - e.stamp), 32'(LAT));
               n_pix++;
            end
         end else begin
            check("blank_rgb_zero", {8'd0, R, G, B}, 32'd0);
         end
         if (!HS) hs_run++;
         else if (hs_run != 0) begin
            check("hs_width", 32'(hs_run), 32'(HSW));
            hs_run = 0;
         end
         if (!VS) vs_run++;
         else if (vs_run != 0) begin
            check("vs_width", 32'(vs_run), 32'(VSW * HT));
            vs_run = 0;
         end
      end
   end

   task automatic d2_case(input string name, input int alpha, input bit en, input logic [29:0] req);
      bit got;
      l2a  = 4'(alpha);
      l2en = en;
      repeat (LAT + 2) @(posedge clk);
      got = 1'b0;
      for (int i = 0; i < HT * VT && !got; i++) begin
         @(negedge clk);
         if (BLANK2) got = 1'b1;
      end
      check({name, "_visible"}, 32'(got), 32'd1);
      check(name, {2'd0, R2, G2, B2}, {2'd0, req});
   endtask

   initial begin
      bit found;
      rst   = 1'b1;
      bg2   = {10'd5, 10'd500, 10'd1000};
      l2rgb = {10'd1023, 10'd1023, 10'd1023};
      l2a   = 4'd0;
      l2en  = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      repeat (2 * HT * VT + 20) @(posedge clk);

      // Mid-frame reset at an active pixel.
      found = 1'b0;
      for (int i = 0; i < HT * VT + 5 && !found; i++) begin
         @(posedge clk);
         #2;
         if (mh == 10 && mv == 3) found = 1'b1;
      end
      check("reset_point_reached", 32'(found), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (2 * HT * VT) @(posedge clk);
      check("pixels_seen", 32'(n_pix >= 3 * HA * VA), 32'd1);

      d2_case("w10_opaque", 15, 1'b1, {10'd1023, 10'd1023, 10'd1023});
      d2_case("w10_transparent", 0, 1'b1, {10'd5, 10'd500, 10'd1000});
      d2_case("w10_half", 8, 1'b1, {10'd514, 10'd730, 10'd949});
      d2_case("w10_disabled", 15, 1'b0, {10'd5, 10'd500, 10'd1000});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
